// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC, one-line fetch buffer, ITLB lookup and an in-order fetch queue.
// Line misses block in MISS until the memory fill returns; an ITLB miss enqueues a trap marker and halts.
`ifndef EXCEPTION_TYPE_ITLBMISS
`define EXCEPTION_TYPE_ITLBMISS 3'd1
`endif

module fetch_unit #(
  parameter int          CACHE_LINE_SIZE = 128,
  parameter logic [31:0] INIT_ADDR       = 32'h1000,
  parameter int          FQ_DEPTH        = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_overwrite_PC,
  input  logic [31:0]                in_overwrite_PC_addr,
  input  logic                       in_branch_taken,
  input  logic [31:0]                in_new_pc,
  input  logic                       in_invalidate,
  input  logic                       in_ready,
  input  logic                       in_itlb_hit,
  input  logic [31:0]                in_itlb_paddr,
  input  logic [CACHE_LINE_SIZE-1:0] in_mem_read_data,
  input  logic                       in_mem_ready,
  output logic [31:0]                out_itlb_vaddr,
  output logic                       out_valid,
  output logic [31:0]                out_PC,
  output logic [31:0]                out_instruction,
  output logic [2:0]                 out_exception_vector,
  output logic                       out_stall,
  output logic                       out_mem_read_en,
  output logic [31:0]                out_mem_addr
);
  localparam int          OFF       = $clog2(CACHE_LINE_SIZE / 8);
  localparam int          NW        = CACHE_LINE_SIZE / 32;
  localparam int          PW        = $clog2(FQ_DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FQ_DEPTH);
  localparam logic [31:0] LINE_MASK = 32'(CACHE_LINE_SIZE / 8 - 1);

  typedef enum logic [1:0] {RUN, MISS, HALT} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [2:0]  exc;
  } fq_entry_t;

  state_t               state, state_nxt;
  logic [31:0]          pc, pc_nxt;
  logic                 line_vld;
  logic [31-OFF:0]      line_tag;
  logic [NW-1:0][31:0]  line_data;
  fq_entry_t            fq [FQ_DEPTH];
  fq_entry_t            enq_entry, head;
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 mem_rd_q;
  logic [31:0]          mem_addr_q;
  logic                 redirect, deq, space, line_hit, enq, start_miss, fill;
  logic [31:0]          redir_tgt;

  assign redirect  = in_overwrite_PC | in_branch_taken;
  assign redir_tgt = (in_overwrite_PC ? in_overwrite_PC_addr : in_new_pc) & 32'hFFFF_FFFC;
  assign deq       = out_valid & in_ready;
  assign space     = (count != FULL_CNT) | deq;
  assign line_hit  = line_vld && (line_tag == in_itlb_paddr[31:OFF]);
  // A stray in_mem_ready outside MISS must not touch the line buffer.
  assign fill      = (state == MISS) && in_mem_ready;

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    enq        = 1'b0;
    enq_entry  = '0;
    start_miss = 1'b0;
    unique case (state)
      RUN: if (space) begin
        if (!in_itlb_hit) begin
          enq       = 1'b1;
          enq_entry = '{pc: pc, instr: 32'h0, exc: `EXCEPTION_TYPE_ITLBMISS};
          state_nxt = HALT;
        end else if (line_hit) begin
          enq       = 1'b1;
          enq_entry = '{pc: pc, instr: line_data[in_itlb_paddr[OFF-1:2]], exc: 3'd0};
          pc_nxt    = pc + 32'd4;
        end else begin
          start_miss = 1'b1;
          state_nxt  = MISS;
        end
      end
      MISS: if (in_mem_ready) state_nxt = RUN;
      default: ;
    endcase
    // Redirects win over everything, but an outstanding fill is still completed.
    if (redirect) begin
      pc_nxt     = redir_tgt;
      enq        = 1'b0;
      start_miss = 1'b0;
      state_nxt  = (state == MISS && !in_mem_ready) ? MISS : RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      pc         <= INIT_ADDR;
      line_vld   <= 1'b0;
      line_tag   <= '0;
      line_data  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (fill) begin
        line_vld  <= 1'b1;
        line_tag  <= mem_addr_q[31:OFF];
        line_data <= in_mem_read_data;
        mem_rd_q  <= 1'b0;
      end else if (in_invalidate) begin
        line_vld <= 1'b0;
      end
      if (start_miss) begin
        mem_rd_q   <= 1'b1;
        mem_addr_q <= in_itlb_paddr & ~LINE_MASK;
      end
      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (enq) wr_ptr <= wr_ptr + 1'b1;
        if (deq) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(enq) - CW'(deq);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) fq[wr_ptr] <= enq_entry;
  end

  assign head                 = fq[rd_ptr];
  assign out_valid            = (count != '0);
  assign out_PC               = out_valid ? head.pc    : 32'h0;
  assign out_instruction      = out_valid ? head.instr : 32'h0;
  assign out_exception_vector = out_valid ? head.exc   : 3'd0;
  assign out_itlb_vaddr       = pc;
  assign out_stall            = !out_valid || (state == MISS);
  assign out_mem_read_en      = mem_rd_q;
  assign out_mem_addr         = mem_addr_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal checks, then randomized traffic,
// all compared every cycle against a queue-based behavioural model.
`ifndef EXCEPTION_TYPE_ITLBMISS
`define EXCEPTION_TYPE_ITLBMISS 3'd1
`endif

module tb_fetch_unit;
  localparam int          CLS  = 128;
  localparam int          FQ   = 4;
  localparam int          LB   = CLS / 8;
  localparam int          OFF  = 4;
  localparam logic [31:0] INIT = 32'h1000;
  localparam int M_RUN = 0, M_MISS = 1, M_HALT = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_overwrite_PC, in_branch_taken, in_invalidate, in_ready, in_itlb_hit, in_mem_ready;
  logic [31:0]     in_overwrite_PC_addr, in_new_pc, in_itlb_paddr;
  logic [CLS-1:0]  in_mem_read_data;
  logic [31:0]     out_itlb_vaddr, out_PC, out_instruction, out_mem_addr;
  logic            out_valid, out_stall, out_mem_read_en;
  logic [2:0]      out_exception_vector;

  fetch_unit #(.CACHE_LINE_SIZE(CLS), .INIT_ADDR(INIT), .FQ_DEPTH(FQ)) dut (
    .clk(clk), .reset(reset),
    .in_overwrite_PC(in_overwrite_PC), .in_overwrite_PC_addr(in_overwrite_PC_addr),
    .in_branch_taken(in_branch_taken), .in_new_pc(in_new_pc),
    .in_invalidate(in_invalidate), .in_ready(in_ready),
    .in_itlb_hit(in_itlb_hit), .in_itlb_paddr(in_itlb_paddr),
    .in_mem_read_data(in_mem_read_data), .in_mem_ready(in_mem_ready),
    .out_itlb_vaddr(out_itlb_vaddr), .out_valid(out_valid), .out_PC(out_PC),
    .out_instruction(out_instruction), .out_exception_vector(out_exception_vector),
    .out_stall(out_stall), .out_mem_read_en(out_mem_read_en), .out_mem_addr(out_mem_addr)
  );

  always #5 clk = ~clk;

  // Translation environment: identity or a fixed XOR offset.
  logic xl_mode = 1'b0;
  assign in_itlb_paddr = xl_mode ? (out_itlb_vaddr ^ 32'h0010_0000) : out_itlb_vaddr;

  typedef struct { logic [31:0] pc; logic [31:0] ins; logic [2:0] exc; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc, m_raddr;
  int          m_mode, m_lat, dir_lat;
  bit          m_lvalid, m_req, stray_en, chk_en;
  logic [31:0] m_ltag;
  int          n_chk = 0, n_err = 0;

  function automatic logic [31:0] xl(input logic [31:0] a);
    return xl_mode ? (a ^ 32'h0010_0000) : a;
  endfunction

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a >= 32'h1000 && a < 32'h1010) return 32'h11 * (((a - 32'h1000) >> 2) + 1);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = INIT; m_mode = M_RUN; mq.delete(); m_lvalid = 0; m_req = 0; m_raddr = 32'h0;
    m_ltag = 32'h0; m_lat = 0;
  endtask

  // One clock of the specified behaviour, from pre-edge model state and the inputs at the edge.
  task automatic model_step();
    bit pre_miss, deq, redir, space;
    logic [31:0] pa, tgt;
    pre_miss = (m_mode == M_MISS);
    deq   = (mq.size() != 0) && in_ready;
    redir = in_overwrite_PC || in_branch_taken;
    tgt   = in_overwrite_PC ? in_overwrite_PC_addr : in_new_pc;
    tgt   = tgt & 32'hFFFF_FFFC;
    space = (mq.size() < FQ) || deq;
    pa    = xl(m_pc);
    if (deq) void'(mq.pop_front());
    if (m_mode == M_RUN && !redir && space) begin
      if (!in_itlb_hit) begin
        mq.push_back('{m_pc, 32'h0, `EXCEPTION_TYPE_ITLBMISS});
        m_mode = M_HALT;
      end else if (m_lvalid && (pa >> OFF) == m_ltag) begin
        mq.push_back('{m_pc, memword(pa & 32'hFFFF_FFFC), 3'd0});
        m_pc = m_pc + 4;
      end else begin
        m_mode = M_MISS; m_req = 1; m_raddr = pa & ~(LB - 1);
        m_lat = (dir_lat >= 0) ? dir_lat : int'($urandom_range(0, 3));
      end
    end
    if (pre_miss && in_mem_ready) begin
      m_lvalid = 1; m_ltag = m_raddr >> OFF; m_req = 0; m_mode = M_RUN;
    end else if (in_invalidate) m_lvalid = 0;
    if (redir) begin
      mq.delete();
      m_pc = tgt;
      if (!pre_miss || in_mem_ready) m_mode = M_RUN;
    end
  endtask

  task automatic drive_mem();
    if (m_mode == M_MISS) begin
      if (m_lat == 0) begin
        in_mem_ready = 1'b1;
        for (int i = 0; i < CLS / 32; i++) in_mem_read_data[32*i +: 32] = memword(m_raddr + 4 * i);
      end else begin
        m_lat--;
        in_mem_ready = 1'b0;
        in_mem_read_data = {$urandom, $urandom, $urandom, $urandom};
      end
    end else begin
      in_mem_ready = stray_en && ($urandom % 8 == 0);
      in_mem_read_data = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic step();
    drive_mem();
    @(posedge clk);
    if (!reset) model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    step();
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("itlb_vaddr", out_itlb_vaddr, m_pc);
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("out_PC", out_PC, mq.size() != 0 ? mq[0].pc : 32'h0);
      chk("out_instruction", out_instruction, mq.size() != 0 ? mq[0].ins : 32'h0);
      chk("out_exception", 32'(out_exception_vector), mq.size() != 0 ? 32'(mq[0].exc) : 32'h0);
      chk("out_stall", 32'(out_stall), 32'(mq.size() == 0 || m_mode == M_MISS));
      chk("mem_read_en", 32'(out_mem_read_en), 32'(m_req));
      chk("mem_addr", out_mem_addr, m_raddr);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_overwrite_PC = 0; in_branch_taken = 0; in_invalidate = 0; in_ready = 0;
    in_itlb_hit = 1; in_mem_ready = 0; in_overwrite_PC_addr = 0; in_new_pc = 0;
    in_mem_read_data = '0; stray_en = 0; dir_lat = 1; chk_en = 0;
    model_reset();
    #3;
    chk("rst_vaddr", out_itlb_vaddr, 32'h1000);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_rd_en", 32'(out_mem_read_en), 32'h0);
    chk("rst_addr", out_mem_addr, 32'h0);
    chk("rst_pc", out_PC, 32'h0);
    chk("rst_instr", out_instruction, 32'h0);
    chk("rst_exc", 32'(out_exception_vector), 32'h0);
    chk_en = 1;
    @(posedge clk); #1;
    reset = 1'b0;

    // First line request and queue fill with the head held.
    step();
    chk("req1_en", 32'(out_mem_read_en), 32'h1);
    chk("req1_addr", out_mem_addr, 32'h1000);
    for (int i = 0; i < 9; i++) step();
    chk("full_pc", out_itlb_vaddr, 32'h1010);
    chk("full_stall", 32'(out_stall), 32'h0);
    chk("full_rd_en", 32'(out_mem_read_en), 32'h0);

    // Drain: one entry per cycle; the 0x1010 miss starts on the first dequeue.
    dir_lat = 6;
    in_ready = 1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_pc", out_PC, 32'h1000 + 32'(4 * k));
      chk("drain_instr", out_instruction, 32'h11 * 32'(k + 1));
      chk("drain_exc", 32'(out_exception_vector), 32'h0);
      step();
    end

    // Branch during MISS keeps the request alive.
    in_branch_taken = 1; in_new_pc = 32'h6000;
    step();
    in_branch_taken = 0;
    dir_lat = 1;
    chk("mbr_rd_en", 32'(out_mem_read_en), 32'h1);
    chk("mbr_addr", out_mem_addr, 32'h1010);
    chk("mbr_vaddr", out_itlb_vaddr, 32'h6000);
    for (int i = 0; i < 4; i++) step();
    chk("mbr_next_en", 32'(out_mem_read_en), 32'h1);
    chk("mbr_next_addr", out_mem_addr, 32'h6000);

    // ITLB miss -> trap entry, HALT, then overwrite with an unaligned target.
    for (int i = 0; i < 20 && m_mode == M_MISS; i++) step();
    in_overwrite_PC = 1; in_overwrite_PC_addr = 32'h2000;
    step();
    in_overwrite_PC = 0; in_itlb_hit = 0; in_ready = 0;
    step();
    chk("itlb_valid", 32'(out_valid), 32'h1);
    chk("itlb_pc", out_PC, 32'h2000);
    chk("itlb_instr", out_instruction, 32'h0);
    chk("itlb_exc", 32'(out_exception_vector), 32'(`EXCEPTION_TYPE_ITLBMISS));
    in_itlb_hit = 1;
    for (int i = 0; i < 3; i++) step();
    chk("halt_vaddr", out_itlb_vaddr, 32'h2000);
    chk("halt_rd_en", 32'(out_mem_read_en), 32'h0);
    in_overwrite_PC = 1; in_overwrite_PC_addr = 32'h3003;
    step();
    in_overwrite_PC = 0;
    chk("ow_vaddr", out_itlb_vaddr, 32'h3000);
    chk("ow_valid", 32'(out_valid), 32'h0);
    step();
    chk("ow_run_addr", out_mem_addr, 32'h3000);

    // Three queued entries, branch and overwrite together.
    for (int i = 0; i < 40 && mq.size() != 3; i++) step();
    chk("q3_reached", 32'(mq.size()), 32'h3);
    in_branch_taken = 1; in_new_pc = 32'h4000; in_overwrite_PC = 1; in_overwrite_PC_addr = 32'h5000;
    step();
    in_branch_taken = 0; in_overwrite_PC = 0;
    chk("both_valid", 32'(out_valid), 32'h0);
    chk("both_vaddr", out_itlb_vaddr, 32'h5000);

    // Invalidate a valid line: the next miss re-requests the same line.
    in_ready = 1;
    for (int i = 0; i < 40 && !(m_pc == 32'h5004 && m_mode == M_RUN); i++) step();
    in_invalidate = 1;
    step();
    in_invalidate = 0;
    step();
    chk("inv_rd_en", 32'(out_mem_read_en), 32'h1);
    chk("inv_addr", out_mem_addr, 32'h5000);

    // Randomized traffic.
    dir_lat = -1; stray_en = 1;
    for (int c = 0; c < 3000; c++) begin
      in_itlb_hit          = ($urandom % 20) != 0;
      in_ready             = ($urandom % 2) == 0;
      in_branch_taken      = ($urandom % 30) == 0;
      in_new_pc            = $urandom_range(32'h1000, 32'h9FFF);
      in_overwrite_PC      = ($urandom % 60) == 0;
      in_overwrite_PC_addr = $urandom_range(32'h1000, 32'h9FFF);
      in_invalidate        = ($urandom % 25) == 0;
      if ($urandom % 100 == 0) xl_mode = ~xl_mode;
      if ($urandom % 400 == 0) do_reset();
      else step();
    end

    @(posedge clk); #1;
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter CACHE_LINE_SIZE, default 128, meaning memory line width in bits (power of 2, >=64).
REQ-002 SHALL have parameter INIT_ADDR, default 32'h1000, meaning PC loaded on reset.
REQ-003 SHALL have parameter FQ_DEPTH, default 4, meaning fetch-queue entries (power of 2, >=2).
REQ-004 SHALL have ports, in order:
- clk  in  1  sole clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high reset
- in_overwrite_PC  in  1  exception/trap redirect request
- in_overwrite_PC_addr  in  32  exception redirect target
- in_branch_taken  in  1  branch redirect request
- in_new_pc  in  32  branch redirect target
- in_invalidate  in  1  clear the line buffer
- in_ready  in  1  downstream accepts the queue head
- in_itlb_hit  in  1  combinational translation hit for out_itlb_vaddr
- in_itlb_paddr  in  32  translated physical address
- in_mem_read_data  in  CACHE_LINE_SIZE  returned line
- in_mem_ready  in  1  read complete; data valid this cycle
- out_itlb_vaddr  out  32  current fetch PC
- out_valid  out  1  queue head valid
- out_PC  out  32  head PC
- out_instruction  out  32  head instruction
- out_exception_vector  out  3  head exception code
- out_stall  out  1  queue empty, or state MISS
- out_mem_read_en  out  1  line read request
- out_mem_addr  out  32  line-aligned physical address

Function
REQ-005 SHALL hold a fetch PC, one line buffer (valid bit, line tag = paddr[31:log2(CACHE_LINE_SIZE/8)], data), and a FIFO of FQ_DEPTH entries {PC, instruction, exception_vector}.
REQ-006 SHALL implement FSM states RUN, MISS, HALT.
REQ-007 RUN: on in_itlb_hit, tag match, line valid and queue not full (or full with head dequeued this cycle), SHALL enqueue the selected word and advance PC by 4.
REQ-008 Word select SHALL be paddr[log2(CACHE_LINE_SIZE/8)-1:2]; word 0 = bits [31:0].
REQ-009 RUN, in_itlb_hit, line miss -> SHALL go to MISS and assert out_mem_read_en with out_mem_addr = paddr with low log2(CACHE_LINE_SIZE/8) bits zero.
REQ-010 MISS: out_mem_read_en and out_mem_addr SHALL stay constant until the cycle in_mem_ready=1; that edge loads line data/tag, sets valid, and returns to RUN (no enqueue that cycle).
REQ-011 RUN, in_itlb_hit=0, space available -> SHALL enqueue {PC, 32'h0, `EXCEPTION_TYPE_ITLBMISS} and go to HALT; PC does not advance.
REQ-012 HALT SHALL enqueue nothing and issue no memory request until a redirect.
REQ-013 Dequeue SHALL occur when out_valid && in_ready; out_* head fields are registered FIFO outputs, 0 when empty.
REQ-014 Redirect priority: in_overwrite_PC over in_branch_taken; target low 2 bits forced to 0.
REQ-015 On redirect SHALL, at that edge: flush queue (count 0), load PC with target, suppress any enqueue; RUN/HALT -> RUN.
REQ-016 Redirect in MISS SHALL not drop the request: PC updates, FSM stays in MISS until in_mem_ready, line still fills, then RUN at the new PC.
REQ-017 in_invalidate SHALL clear line valid; if coincident with in_mem_ready in MISS, the fill wins (valid=1).
REQ-018 Enqueue and dequeue in the same cycle SHALL keep count unchanged; full with no dequeue SHALL hold PC.
REQ-019 FIFO pointers SHALL wrap modulo FQ_DEPTH; count width log2(FQ_DEPTH)+1.
REQ-020 The fetch unit SHALL issue no memory writes.

Reset
REQ-021 reset SHALL immediately set PC=INIT_ADDR, state RUN, queue empty, line invalid, out_valid=0, out_mem_read_en=0, out_mem_addr=0, out_PC/out_instruction/out_exception_vector=0.
REQ-022 reset asserted mid-MISS SHALL abandon the request; a later in_mem_ready SHALL be ignored while not in MISS.

Verification
REQ-023 Reset, itlb hit identity, memory returns line with words 0x11,0x22,0x33,0x44 at 0x1000 -> one request addr 0x1000; entries PC 0x1000..0x100C with those instructions, exception 0.
REQ-024 Queue full (in_ready=0, FQ_DEPTH=4) -> out_stall=0, PC held at 0x1010 line miss deferred until dequeue; with in_ready=1 one entry per cycle thereafter.
REQ-025 in_itlb_hit=0 at PC 0x2000 -> single entry {0x2000, 0, ITLBMISS}, then HALT; in_overwrite_PC=1 to 0x3003 -> PC 0x3000, RUN.
REQ-026 Branch to 0x4000 and overwrite to 0x5000 same cycle, queue holding 3 entries -> queue empty next cycle, PC 0x5000.
REQ-027 Branch to 0x6000 while MISS on 0x1010 -> read_en held to in_mem_ready, line 0x1010 filled, next request addr 0x6000.
REQ-028 in_invalidate with line 0x1000 valid -> next fetch at 0x1004 re-requests 0x1000.
